// File: rtl/day10_line_parser.sv
// Day-10 line parser: ASCII machine lines in, flat descriptor out.
// Descriptor is handed off with a start/ready/accepted handshake.
module day10_line_parser #(
  parameter int MAX_NUM_LIGHTS  = 6,
  parameter int MAX_NUM_BUTTONS = 6,
  localparam int MAX_NUM_LIGHTS_W =
    (MAX_NUM_LIGHTS <= 1) ? 1 : $clog2(MAX_NUM_LIGHTS + 1),
  localparam int MAX_NUM_BUTTONS_W =
    (MAX_NUM_BUTTONS <= 1) ? 1 : $clog2(MAX_NUM_BUTTONS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [MAX_NUM_LIGHTS-1:0]     target_lights,
  output logic [MAX_NUM_LIGHTS_W-1:0]   num_lights,
  output logic [MAX_NUM_BUTTONS-1:0]
               [MAX_NUM_LIGHTS-1:0]     button_masks,
  output logic [MAX_NUM_BUTTONS_W-1:0]  num_buttons,
  output logic                          start,
  input  logic                          ready,
  input  logic                          accepted,
  output logic                          parse_error
);

  localparam int IDXW = 8;
  localparam int LW   = MAX_NUM_LIGHTS_W;
  localparam int BW   = MAX_NUM_BUTTONS_W;

  typedef enum logic [2:0] {
    IDLE, LIGHTS, SEP, BUTTON, JOLT, EOL, EMIT, HOLD
  } state_t;

  state_t state_q, state_d;
  logic [MAX_NUM_LIGHTS-1:0] tgt_q, tgt_d;
  logic [LW-1:0] nl_q, nl_d;
  logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] masks_q, masks_d;
  logic [BW-1:0] nb_q, nb_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic discard_q, discard_d;
  logic start_q, start_d;
  logic err_q, err_d;
  logic tready_q, tready_d;

  logic [7:0] ch;
  logic fire, is_cr, is_nl, eol, is_dig, line_done;
  logic [11:0] acc;

  assign ch     = s_axis_tdata;
  assign fire   = s_axis_tvalid & tready_q;
  assign is_cr  = (ch == 8'h0D);
  assign is_nl  = (ch == 8'h0A);
  assign eol    = is_nl | s_axis_tlast;
  assign is_dig = (ch >= "0") && (ch <= "9");
  assign acc    = 12'(idx_q) * 12'd10 + 12'(ch[3:0]);

  // Next-state, descriptor update and handshake decode.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    nl_d      = nl_q;
    masks_d   = masks_q;
    nb_d      = nb_q;
    idx_d     = idx_q;
    discard_d = discard_q;
    err_d     = err_q;
    start_d   = 1'b0;
    line_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fire && ch == "[") begin
          tgt_d     = '0;
          nl_d      = '0;
          masks_d   = '0;
          nb_d      = '0;
          idx_d     = '0;
          discard_d = 1'b0;
          state_d   = LIGHTS;
        end
      end
      LIGHTS: begin
        if (fire && !is_cr) begin
          if (eol) begin
            err_d     = 1'b1;
            line_done = 1'b1;
          end else if (ch == "." || ch == "#") begin
            if (nl_q < LW'(MAX_NUM_LIGHTS)) begin
              for (int i = 0; i < MAX_NUM_LIGHTS; i++)
                if (nl_q == LW'(i))
                  tgt_d[i] = (ch == "#");
              nl_d = nl_q + 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (ch == "]") begin
            state_d = SEP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEP: begin
        if (fire && !is_cr) begin
          if (eol) begin
            line_done = 1'b1;
          end else if (ch == "(") begin
            idx_d     = '0;
            discard_d = (nb_q == BW'(MAX_NUM_BUTTONS));
            if (nb_q == BW'(MAX_NUM_BUTTONS))
              err_d = 1'b1;
            state_d = BUTTON;
          end else if (ch == "{") begin
            state_d = JOLT;
          end else if (ch != " ") begin
            err_d = 1'b1;
          end
        end
      end
      BUTTON: begin
        if (fire && !is_cr) begin
          if (eol) begin
            err_d     = 1'b1;
            line_done = 1'b1;
          end else if (is_dig) begin
            // Saturate so an oversized index can never wrap into range.
            idx_d = (acc > 12'd255) ? 8'hFF : acc[7:0];
          end else if (ch == "," || ch == ")") begin
            if (!discard_q) begin
              if (idx_q >= IDXW'(nl_q)) begin
                err_d = 1'b1;
              end else begin
                for (int b = 0; b < MAX_NUM_BUTTONS; b++)
                  for (int i = 0; i < MAX_NUM_LIGHTS; i++)
                    if (nb_q == BW'(b) && idx_q == IDXW'(i))
                      masks_d[b][i] = 1'b1;
              end
            end
            idx_d = '0;
            if (ch == ")") begin
              if (!discard_q)
                nb_d = nb_q + 1'b1;
              state_d = SEP;
            end
          end else if (ch != " ") begin
            err_d = 1'b1;
          end
        end
      end
      JOLT: begin
        if (fire && !is_cr) begin
          if (eol)
            line_done = 1'b1;
          else if (ch == "}")
            state_d = EOL;
        end
      end
      EOL: begin
        if (fire && !is_cr && eol)
          line_done = 1'b1;
      end
      EMIT: begin
        if (ready) begin
          start_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (accepted)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Skip EMIT entirely when the configurator is already waiting.
    if (line_done) begin
      if (ready) begin
        start_d = 1'b1;
        state_d = HOLD;
      end else begin
        state_d = EMIT;
      end
    end

    tready_d = !(state_d == EMIT || state_d == HOLD);
  end

  // State and descriptor registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      nl_q      <= '0;
      masks_q   <= '0;
      nb_q      <= '0;
      idx_q     <= '0;
      discard_q <= 1'b0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      tready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      nl_q      <= nl_d;
      masks_q   <= masks_d;
      nb_q      <= nb_d;
      idx_q     <= idx_d;
      discard_q <= discard_d;
      start_q   <= start_d;
      err_q     <= err_d;
      tready_q  <= tready_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign target_lights = tgt_q;
  assign num_lights    = nl_q;
  assign button_masks  = masks_q;
  assign num_buttons   = nb_q;
  assign start         = start_q;
  assign parse_error   = err_q;

endmodule

// File: tb/tb_day10_line_parser.sv
// Scoreboard bench for day10_line_parser.
// Directed lines; monitor checks each start pulse against the queue.
module tb_day10_line_parser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tready;
  logic s_axis_tlast = 1'b0;
  logic [5:0] target_lights;
  logic [2:0] num_lights;
  logic [5:0][5:0] button_masks;
  logic [2:0] num_buttons;
  logic start;
  logic ready = 1'b1;
  logic accepted = 1'b0;
  logic parse_error;

  int checks = 0;
  int errors = 0;
  int nstarts = 0;
  int acc_delay = 1;

  typedef struct packed {
    logic [5:0]  tgt;
    logic [2:0]  nl;
    logic [2:0]  nb;
    logic [35:0] m;
    logic        err;
  } exp_t;

  exp_t sb[$];

  day10_line_parser dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .target_lights(target_lights), .num_lights(num_lights),
    .button_masks(button_masks), .num_buttons(num_buttons),
    .start(start), .ready(ready), .accepted(accepted),
    .parse_error(parse_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic exp_t mk(input logic [5:0] t, input logic [2:0] nl,
                              input logic [2:0] nb, input logic [35:0] m,
                              input logic er);
    exp_t x;
    x.tgt = t; x.nl = nl; x.nb = nb; x.m = m; x.err = er;
    return x;
  endfunction

  // Caller is at a negedge; returns at the negedge after the handshake.
  task automatic send_byte(input logic [7:0] b, input logic l);
    int n = 0;
    s_axis_tdata = b;
    s_axis_tlast = l;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!s_axis_tready) begin
      chk("tready_timeout", 64'(s_axis_tready), 64'd1);
    end
    @(negedge clk);
  endtask

  task automatic send_str(input string s, input logic last_final);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], last_final && (i == s.len() - 1));
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
  endtask

  // Monitor: every start pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && start) begin
      nstarts++;
      if (sb.size() == 0) begin
        chk("unexpected_start", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("target_lights", 64'(target_lights), 64'(e.tgt));
        chk("num_lights", 64'(num_lights), 64'(e.nl));
        chk("num_buttons", 64'(num_buttons), 64'(e.nb));
        chk("button_masks", 64'(button_masks), 64'(e.m));
        chk("parse_error", 64'(parse_error), 64'(e.err));
      end
    end
  end

  // Configurator model: accepts acc_delay cycles after each start.
  always @(negedge clk) begin
    if (rst_n && start) begin
      repeat (acc_delay) @(negedge clk);
      accepted = 1'b1;
      @(negedge clk);
      accepted = 1'b0;
    end
  end

  string l1;
  initial begin
    l1 = "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n";

    @(negedge clk);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_masks", 64'(button_masks), 64'd0);
    chk("rst_err", 64'(parse_error), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", 64'(s_axis_tready), 64'd1);

    // Reference line, ready high.
    sb.push_back(mk(6'b000110, 3'd4, 3'd6,
      {6'b000011, 6'b000101, 6'b001100,
       6'b000100, 6'b001010, 6'b001000}, 1'b0));
    send_str(l1, 1'b0);
    chk("t1_latency_start", 64'(start), 64'd1);
    repeat (4) @(negedge clk);

    // Same line, configurator busy for 10 cycles.
    ready = 1'b0;
    acc_delay = 3;
    sb.push_back(mk(6'b000110, 3'd4, 3'd6,
      {6'b000011, 6'b000101, 6'b001100,
       6'b000100, 6'b001010, 6'b001000}, 1'b0));
    send_str(l1, 1'b0);
    repeat (10) begin
      chk("t2_wait_tready", 64'(s_axis_tready), 64'd0);
      chk("t2_wait_start", 64'(start), 64'd0);
      @(negedge clk);
    end
    ready = 1'b1;
    begin
      int n = 0;
      while (!start && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t2_start", 64'(start), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_hold_tready", 64'(s_axis_tready), 64'd0);
      chk("t2_hold_target", 64'(target_lights), 64'h06);
      chk("t2_hold_masks", 64'(button_masks), 64'h0C5304288);
    end
    @(negedge clk);
    chk("t2_tready_after_acc", 64'(s_axis_tready), 64'd1);
    acc_delay = 1;

    // Back-to-back lines, second ends on tlast, preceded by blank lines.
    sb.push_back(mk(6'b000110, 3'd4, 3'd6,
      {6'b000011, 6'b000101, 6'b001100,
       6'b000100, 6'b001010, 6'b001000}, 1'b0));
    sb.push_back(mk(6'b000001, 3'd1, 3'd1, 36'h1, 1'b0));
    send_str(l1, 1'b0);
    send_str("\n\r\n[#] (0) {1}", 1'b1);
    repeat (4) @(negedge clk);

    // Out-of-range index: error, start still issued.
    sb.push_back(mk(6'b0, 3'd2, 3'd1, 36'h0, 1'b1));
    send_str("[..] (5)\n", 1'b0);
    repeat (4) @(negedge clk);

    // Seven groups: seventh discarded.
    sb.push_back(mk(6'b0, 3'd4, 3'd6,
      {6'b001100, 6'b000011, 6'b001000,
       6'b000100, 6'b000010, 6'b000001}, 1'b1));
    send_str("[....] (0) (1) (2) (3) (0,1) (2,3) (0,3)\n", 1'b0);
    repeat (4) @(negedge clk);

    // Reset in the middle of a button group.
    send_str("[#.] (1", 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_target", 64'(target_lights), 64'd0);
    chk("mid_rst_nl", 64'(num_lights), 64'd0);
    chk("mid_rst_nb", 64'(num_buttons), 64'd0);
    chk("mid_rst_err", 64'(parse_error), 64'd0);
    chk("mid_rst_tready", 64'(s_axis_tready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_tready_up", 64'(s_axis_tready), 64'd1);
    sb.push_back(mk(6'b000010, 3'd2, 3'd2,
      {24'b0, 6'b000010, 6'b000011}, 1'b0));
    send_str("[.#] (0,1) (1) {7}\r\n", 1'b0);
    repeat (6) @(negedge clk);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("start_count", 64'(nstarts), 64'd7);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/day10_line_parser.md
Name: day10_line_parser

Overview:
- Upstream stage of the day-10 machine configurator. Consumes the puzzle input as an ASCII byte AXI-Stream.
- Parses one machine line at a time: light diagram, button wiring groups, joltage group.
- Produces a flat machine descriptor: target light mask, light count, per-button toggle masks, button count.
- Hands the descriptor to the configurator via the start/ready/accepted handshake. The top level packs these outputs into day10_input_if.

Parameters:
- MAX_NUM_LIGHTS, 6, maximum lights per machine; width of every light mask.
- MAX_NUM_BUTTONS, 6, maximum buttons per machine.
- MAX_NUM_LIGHTS_W, derived: (MAX_NUM_LIGHTS<=1)?1:$clog2(MAX_NUM_LIGHTS+1).
- MAX_NUM_BUTTONS_W, derived: (MAX_NUM_BUTTONS<=1)?1:$clog2(MAX_NUM_BUTTONS+1).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  8  ASCII input byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  byte accepted when tvalid&tready.
- s_axis_tlast  in  1  last byte of file; terminates a line like '\n'.
- target_lights  out  MAX_NUM_LIGHTS  bit i = 1 when light i is '#'.
- num_lights  out  MAX_NUM_LIGHTS_W  count of '.'/'#' characters.
- button_masks  out  MAX_NUM_BUTTONS x MAX_NUM_LIGHTS  mask b has bit i set when button b toggles light i.
- num_buttons  out  MAX_NUM_BUTTONS_W  number of '(' groups.
- start  out  1  one-cycle pulse: descriptor valid, configurator may begin.
- ready  in  1  configurator idle and able to take a descriptor.
- accepted  in  1  one-cycle pulse: configurator has latched descriptor.
- parse_error  out  1  sticky; cleared only by reset.

Behaviour:
- Reset: state=IDLE. All descriptor outputs 0, start=0, parse_error=0, s_axis_tready=0 during reset and 1 in the first cycle after reset.
- States: IDLE, LIGHTS, SEP, BUTTON, JOLT, EOL, EMIT, HOLD. One byte is consumed per handshake cycle.
- IDLE: discards bytes until '['. On '[', clears all descriptor registers and goes to LIGHTS.
- LIGHTS:
  - '.' or '#' sets bit num_lights to 0 or 1 and increments num_lights.
  - ']' goes to SEP.
  - A light beyond MAX_NUM_LIGHTS sets parse_error; the bit is dropped and the count saturates.
- SEP: ' ' is ignored. '(' goes to BUTTON. '{' goes to JOLT. '\n' or tlast goes to EMIT. Any other byte sets parse_error.
- BUTTON:
  - Decimal digits accumulate into an index register (idx = idx*10 + d).
  - ',' or ')' ORs bit idx into button_masks[num_buttons]; the index register then clears.
  - ')' also increments num_buttons and returns to SEP.
  - idx >= num_lights sets parse_error and the bit is not set.
  - A '(' when num_buttons == MAX_NUM_BUTTONS sets parse_error; that group is parsed but discarded.
- JOLT: all bytes are ignored until '}', which goes to EOL. A '\n' or tlast inside JOLT goes straight to EMIT.
- EOL: ignores bytes until '\n' or tlast, then goes to EMIT.
- Stream back-pressure: s_axis_tready=1 in IDLE through EOL, and 0 in EMIT and HOLD. No byte is consumed during EMIT or HOLD.
- EMIT: waits for ready=1. When ready is high, start pulses for exactly one cycle and the state goes to HOLD.
- HOLD:
  - Descriptor outputs stay stable until accepted=1.
  - On accepted, the state goes to IDLE; s_axis_tready rises the next cycle.
  - If accepted and ready arrive in the same cycle, accepted wins; no second start is issued.
- Latency: start asserts at the earliest one cycle after the handshake of the line-terminating byte, given ready=1.
- Empty lines ('\n' in IDLE) are ignored. A line with zero buttons is still emitted with num_buttons=0.
- '\r' is ignored in every state.
- Reset mid-line or mid-HOLD aborts the descriptor immediately; start never re-fires for the aborted line.

Test Plan:
- Feed "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n" with ready=1. Expect one start pulse with target_lights=6'b000110, num_lights=4, num_buttons=6, button_masks = 1000, 1010, 0100, 1100, 0101, 0011 (lights 3..0).
- Same line with ready=0 for 10 cycles, then ready=1, accepted pulse 3 cycles after start. Expect s_axis_tready=0 throughout the wait, a single start, outputs stable until accepted, and tready=1 the cycle after accepted.
- Two back-to-back lines, the second "[#] (0) {1}" ending with tlast and no '\n'. Expect two start pulses; the second has target=1, num_lights=1, num_buttons=1, mask0=1.
- Line "[..] (5)\n". Expect parse_error=1, mask0=0, num_buttons=1, and start still issued.
- Seven button groups with MAX_NUM_BUTTONS=6. Expect num_buttons=6, parse_error=1, and the seventh mask discarded.
- Assert rst_n=0 mid-BUTTON. Expect all outputs 0 and state IDLE; a following valid line parses correctly.
